simon_input_handler: RTL
========================

# simon_input_handler

Player-input stage of the Simon game, downstream of the game controller's sequence/ready outputs and upstream of the score logic. It synchronises and debounces four raw colour buttons and records each accepted press into the user sequence. Each press is checked against the expected colour of the active player's sequence, and the block reports round success (score-update pulse) or failure. It drives the consumer-side controls of the shared control interface: incolor, user sequence, user position and score update.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples required to accept a press or a release; must be ≥1.
- MAX_LEN, 16: maximum sequence length in colours.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- btn_i  in  4  raw buttons; bit0 Green, bit1 Yellow, bit2 Red, bit3 Blue.
- ready_i  in  1  controller ready; high = input window open.
- player_i  in  1  0 = check against seq_p1_i, 1 = seq_p2_i.
- seq_p1_i / seq_p2_i  in  32  expected colours, colour k at [2k+1:2k] (0 G, 1 Y, 2 R, 3 B).
- seq_len_i  in  5  round length, 1..16.
- incolor_o  out  4  one-hot colour of the last accepted press.
- user_seq_o  out  64  accepted presses, press k one-hot at [4k+3:4k].
- user_pos_o  out  5  count of correct presses this round; zero-extended by the interface wrapper.
- score_update_o  out  1  one-cycle pulse on round success.
- correct_o  out  1  level; high after success until the next round starts.
- error_o  out  1  one-cycle pulse on mismatch.
- busy_o  out  1  high in every state except IDLE.

## Operation
- Reset (rst_n low at an edge):
  - All outputs are cleared to 0.
  - The FSM goes to IDLE.
  - Synchroniser and debounce counter are cleared.
  - Reset has priority over every other event, mid-round included.
- Buttons pass through a 2-flop synchroniser to produce btn_s.
- FSM states: IDLE, ARMED, WAIT_PRESS, WAIT_RELEASE, DONE, FAIL.
- **IDLE**
  - On ready_i = 1 and 1 ≤ seq_len_i ≤ MAX_LEN:
    - Latch player_i, the selected sequence and seq_len_i.
    - Clear user_seq_o, user_pos_o and correct_o.
    - Go to ARMED.
  - If seq_len_i is 0 or greater than MAX_LEN, stay in IDLE.
- **ARMED**: wait until btn_s = 0 for DEBOUNCE_CYCLES samples, then go to WAIT_PRESS. A button held from the previous round is never counted.
- **WAIT_PRESS**
  - The debounce counter increments while btn_s is the same single-bit (one-hot) value as on the previous cycle.
  - The counter resets on any change, on zero, or on a multi-bit value. Multi-button presses are never accepted.
  - A press is accepted when the count reaches DEBOUNCE_CYCLES. On acceptance, incolor_o is updated with the pressed colour.
  - Match against the latched expected colour at index user_pos_o:
    - Write the press into user_seq_o slot user_pos_o.
    - Increment user_pos_o.
    - If the new position equals the latched length: pulse score_update_o, set correct_o, go to DONE.
    - Otherwise go to WAIT_RELEASE.
  - Mismatch: pulse error_o, leave user_seq_o and user_pos_o unchanged, go to FAIL.
- **WAIT_RELEASE**: once btn_s = 0 for DEBOUNCE_CYCLES samples, go to WAIT_PRESS.
- **DONE / FAIL**: hold all outputs; go to IDLE when ready_i = 0.
- ready_i falling in ARMED, WAIT_PRESS or WAIT_RELEASE aborts the round:
  - Go to IDLE.
  - Clear user_pos_o and user_seq_o.
  - Do not pulse score_update_o or error_o.
  - If a press is accepted on the same edge as the abort, the abort wins.
- Sequence inputs that change mid-round are ignored, because the round works on latched copies.

## Timing
- Raw button edge to accepted press: the synchroniser costs 2 cycles, then DEBOUNCE_CYCLES cycles. incolor_o, user_seq_o, user_pos_o, score_update_o and error_o all update on the same edge.
- score_update_o and error_o are exactly 1 cycle wide and never asserted together.
- ready_i rising in IDLE makes busy_o high on the next edge.
- In DONE/FAIL, ready_i low makes busy_o low on the next edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- The shared package simon_pkg holds:
  - the color_t enum (GREEN = 0, YELLOW, RED, BLUE);
  - the one-hot/index conversion functions;
  - MAX_LEN;
  - the input-FSM state enum.
- One sub-module is natural: simon_btn_debounce. It contains the synchroniser and stability counter and reports a stable one-hot press and a stable all-released condition.

## Test plan
- Perfect round:
  - Stimulus: seq_len_i = 3, seq_p1_i[5:0] = 6'b10_01_00 (G, Y, R), player_i = 0. Press G, Y, R, each clean and followed by a release.
  - Response: user_pos_o steps 1, 2, 3. user_seq_o[11:0] = 12'h421. One score_update_o pulse on the third accept. correct_o = 1.
- Wrong colour:
  - Stimulus: same round; press G, then B.
  - Response: error_o pulses once. user_pos_o stays 1. incolor_o = 4'b1000. Next state is FAIL.
- Bounce rejection (DEBOUNCE_CYCLES = 4):
  - Stimulus: G toggles with 3-cycle high pulses, then holds steady.
  - Response: exactly one accept, 6 cycles after the steady edge.
- Multi-button and held button:
  - Stimulus: G+R held for 20 cycles. Separately, Y held across ready_i rising.
  - Response: no accept in either case. Y is accepted only after it is released and pressed again.
- Abort and reset:
  - Stimulus: ready_i dropped after 1 correct press. Separately, rst_n low during WAIT_RELEASE.
  - Response: IDLE. user_pos_o = 0, user_seq_o = 0. No pulses.
- Player 2 select:
  - Stimulus: player_i = 1, seq_p2_i[1:0] = 2'b11, seq_len_i = 1. Press B.
  - Response: score_update_o pulses and correct_o = 1. seq_p1_i is ignored.

Source files
------------

// File: rtl/simon_input_handler_pkg.sv
// Shared types for the Simon game: colour encoding, input-FSM states and
// colour conversion helpers.
package simon_pkg;

    localparam int MAX_LEN = 16;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        BLUE   = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE,
        FAIL
    } in_state_t;

    function automatic logic [3:0] color_to_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

    function automatic color_t onehot_to_color(input logic [3:0] oh);
        case (oh)
            4'b0010: return YELLOW;
            4'b0100: return RED;
            4'b1000: return BLUE;
            default: return GREEN;
        endcase
    endfunction

    // Colour k of a packed sequence lives at bits [2k+1:2k].
    function automatic color_t color_at(input logic [31:0] seq, input logic [3:0] idx);
        return color_t'(seq[{idx, 1'b0} +: 2]);
    endfunction

endpackage

// File: rtl/simon_input_handler_if.sv
// Control interface between the game controller side and the player-input stage.
interface simon_input_handler_if;
    logic [3:0]  btn;
    logic        ready;
    logic        player;
    logic [31:0] seq_p1;
    logic [31:0] seq_p2;
    logic [4:0]  seq_len;
    logic [3:0]  incolor;
    logic [63:0] user_seq;
    logic [4:0]  user_pos;
    logic        score_update;
    logic        correct;
    logic        error;
    logic        busy;

    modport master (
        output btn, ready, player, seq_p1, seq_p2, seq_len,
        input  incolor, user_seq, user_pos, score_update, correct, error, busy
    );

    modport slave (
        input  btn, ready, player, seq_p1, seq_p2, seq_len,
        output incolor, user_seq, user_pos, score_update, correct, error, busy
    );
endinterface

// File: rtl/simon_btn_debounce.sv
// Two-flop button synchroniser plus stability counters; flags the cycle a
// single button becomes stable and the level "all released long enough".
module simon_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [3:0] btn_s,
    output logic       press_valid,
    output logic       released
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [3:0]    meta_reg, sync_reg, last_reg;
    logic [CW-1:0] press_cnt_reg, press_cnt_next;
    logic [CW-1:0] rel_cnt_reg, rel_cnt_next;
    logic          one_hot;

    always_comb begin
        one_hot        = (sync_reg != 4'd0) && ((sync_reg & (sync_reg - 4'd1)) == 4'd0);
        press_cnt_next = '0;
        rel_cnt_next   = '0;
        if (one_hot) begin
            if (sync_reg == last_reg)
                press_cnt_next = (press_cnt_reg == CNT_MAX) ? CNT_MAX : press_cnt_reg + CW'(1);
            else
                press_cnt_next = CW'(1);
        end
        if (sync_reg == 4'd0)
            rel_cnt_next = (rel_cnt_reg == CNT_MAX) ? CNT_MAX : rel_cnt_reg + CW'(1);
    end

    // The counter saturates, so a held button fires exactly once.
    assign press_valid = (press_cnt_next == CNT_MAX) && (press_cnt_reg != CNT_MAX);
    assign released    = (rel_cnt_next == CNT_MAX);
    assign btn_s       = sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg      <= '0;
            sync_reg      <= '0;
            last_reg      <= '0;
            press_cnt_reg <= '0;
            rel_cnt_reg   <= '0;
        end else begin
            meta_reg      <= btn;
            sync_reg      <= meta_reg;
            last_reg      <= sync_reg;
            press_cnt_reg <= press_cnt_next;
            rel_cnt_reg   <= rel_cnt_next;
        end
    end
endmodule

// File: rtl/simon_input_handler.sv
// Simon player-input stage: debounced presses are checked against the latched
// sequence of the active player and reported as round success or failure.
module simon_input_handler
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    simon_input_handler_if.slave  bus
);
    localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

    in_state_t   state_reg;
    logic [31:0] seq_reg;
    logic [4:0]  len_reg;
    logic [3:0]  incolor_reg;
    logic [63:0] user_seq_reg;
    logic [4:0]  user_pos_reg;
    logic        score_reg, correct_reg, error_reg, busy_reg;

    logic [3:0]  btn_s;
    logic        press_valid, released;
    logic [3:0]  expected_oh;
    logic [4:0]  pos_inc;
    logic        len_ok, in_round;

    simon_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (bus.btn),
        .btn_s       (btn_s),
        .press_valid (press_valid),
        .released    (released)
    );

    assign expected_oh = color_to_onehot(color_at(seq_reg, user_pos_reg[3:0]));
    assign pos_inc     = user_pos_reg + 5'd1;
    assign len_ok      = (bus.seq_len != 5'd0) && (bus.seq_len <= MAX_LEN_W);
    assign in_round    = (state_reg == ARMED) || (state_reg == WAIT_PRESS) ||
                         (state_reg == WAIT_RELEASE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            seq_reg      <= '0;
            len_reg      <= '0;
            incolor_reg  <= '0;
            user_seq_reg <= '0;
            user_pos_reg <= '0;
            score_reg    <= 1'b0;
            correct_reg  <= 1'b0;
            error_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            score_reg <= 1'b0;
            error_reg <= 1'b0;
            // Dropping ready mid-round discards progress, even on an accept edge.
            if (in_round && !bus.ready) begin
                state_reg    <= IDLE;
                busy_reg     <= 1'b0;
                user_pos_reg <= '0;
                user_seq_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.ready && len_ok) begin
                            seq_reg      <= bus.player ? bus.seq_p2 : bus.seq_p1;
                            len_reg      <= bus.seq_len;
                            user_seq_reg <= '0;
                            user_pos_reg <= '0;
                            correct_reg  <= 1'b0;
                            busy_reg     <= 1'b1;
                            state_reg    <= ARMED;
                        end
                    end
                    ARMED, WAIT_RELEASE: begin
                        if (released)
                            state_reg <= WAIT_PRESS;
                    end
                    WAIT_PRESS: begin
                        if (press_valid) begin
                            incolor_reg <= btn_s;
                            if (btn_s == expected_oh) begin
                                user_seq_reg[{user_pos_reg[3:0], 2'b00} +: 4] <= btn_s;
                                user_pos_reg <= pos_inc;
                                if (pos_inc == len_reg) begin
                                    score_reg   <= 1'b1;
                                    correct_reg <= 1'b1;
                                    state_reg   <= DONE;
                                end else begin
                                    state_reg <= WAIT_RELEASE;
                                end
                            end else begin
                                error_reg <= 1'b1;
                                state_reg <= FAIL;
                            end
                        end
                    end
                    DONE, FAIL: begin
                        if (!bus.ready) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.incolor      = incolor_reg;
    assign bus.user_seq     = user_seq_reg;
    assign bus.user_pos     = user_pos_reg;
    assign bus.score_update = score_reg;
    assign bus.correct      = correct_reg;
    assign bus.error        = error_reg;
    assign bus.busy         = busy_reg;
endmodule
